// File: rtl/matmul_seq.sv
// matmul_seq: sequencer that computes C = A x B straight out of a shared
// single-port data RAM, using loop counters, one MAC and a small FSM.
// Ports: Clk/Rst (sync, active-high), start + dim_m/k/n + base_a/b/c
// operands, mem_* RAM master, busy/done handshake, sticky overflow.
module matmul_seq #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 8,
  parameter int ACC_W  = 24,
  parameter int SAT    = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] dim_m,
  input  logic [AWIDTH-1:0] dim_k,
  input  logic [AWIDTH-1:0] dim_n,
  input  logic [AWIDTH-1:0] base_a,
  input  logic [AWIDTH-1:0] base_b,
  input  logic [AWIDTH-1:0] base_c,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_RDA, S_RDB, S_MAC, S_WR, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [AWIDTH-1:0] dm_q, dm_d, dk_q, dk_d, dn_q, dn_d;
  logic [AWIDTH-1:0] ba_q, ba_d, bb_q, bb_d, bc_q, bc_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  a_reg_q, a_reg_d;
  logic              ovf_q, ovf_d;

  logic [AWIDTH-1:0] addr_a, addr_b, addr_c;
  logic [ACC_W-1:0]  prod;
  logic              too_big;
  logic              last_k, last_i, last_j;

  // Address arithmetic wraps at AWIDTH bits by construction.
  assign addr_a = ba_q + i_q * dk_q + k_q;
  assign addr_b = bb_q + k_q * dn_q + j_q;
  assign addr_c = bc_q + i_q * dn_q + j_q;

  assign prod    = ACC_W'(a_reg_q) * ACC_W'(mem_rdata);
  assign too_big = |acc_q[ACC_W-1:WIDTH];
  assign last_k  = (k_q == dk_q - AWIDTH'(1));
  assign last_i  = (i_q == dm_q - AWIDTH'(1));
  assign last_j  = (j_q == dn_q - AWIDTH'(1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      dm_q    <= '0;
      dk_q    <= '0;
      dn_q    <= '0;
      ba_q    <= '0;
      bb_q    <= '0;
      bc_q    <= '0;
      acc_q   <= '0;
      a_reg_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      dm_q    <= dm_d;
      dk_q    <= dk_d;
      dn_q    <= dn_d;
      ba_q    <= ba_d;
      bb_q    <= bb_d;
      bc_q    <= bc_d;
      acc_q   <= acc_d;
      a_reg_q <= a_reg_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    dm_d    = dm_q;
    dk_d    = dk_q;
    dn_d    = dn_q;
    ba_d    = ba_q;
    bb_d    = bb_q;
    bc_d    = bc_q;
    acc_d   = acc_q;
    a_reg_d = a_reg_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dm_d  = dim_m;
          dk_d  = dim_k;
          dn_d  = dim_n;
          ba_d  = base_a;
          bb_d  = base_b;
          bc_d  = base_c;
          acc_d = '0;
          i_d   = '0;
          j_d   = '0;
          k_d   = '0;
          ovf_d = 1'b0;
          if (dim_m == '0 || dim_k == '0 || dim_n == '0)
            state_d = S_DONE;
          else
            state_d = S_RDA;
        end
      end
      S_RDA: state_d = S_RDB;
      S_RDB: begin
        a_reg_d = mem_rdata;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + prod;
        if (last_k) begin
          state_d = S_WR;
        end else begin
          k_d     = k_q + AWIDTH'(1);
          state_d = S_RDA;
        end
      end
      S_WR: begin
        if (too_big) ovf_d = 1'b1;
        acc_d = '0;
        k_d   = '0;
        if (last_i && last_j) begin
          state_d = S_DONE;
        end else if (last_j) begin
          j_d     = '0;
          i_d     = i_q + AWIDTH'(1);
          state_d = S_RDA;
        end else begin
          j_d     = j_q + AWIDTH'(1);
          state_d = S_RDA;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: ;
      S_RDA: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = addr_a;
      end
      S_RDB: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = addr_b;
      end
      S_MAC: busy = 1'b1;
      S_WR: begin
        busy     = 1'b1;
        mem_wr   = 1'b1;
        mem_addr = addr_c;
        if (too_big && SAT != 0)
          mem_wdata = '1;
        else
          mem_wdata = acc_q[WIDTH-1:0];
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign overflow = ovf_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq: directed runs with a write scoreboard.
// A SAT=1 and a SAT=0 instance share one RAM model via a select.
module tb_matmul_seq;
  localparam int W  = 8;
  localparam int AW = 8;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          start = 1'b0;
  logic          sel = 1'b0;
  logic [AW-1:0] dim_m = '0, dim_k = '0, dim_n = '0;
  logic [AW-1:0] base_a = '0, base_b = '0, base_c = '0;
  logic [W-1:0]  mem_rdata = '0;

  logic [AW-1:0] a1, a0, mem_addr;
  logic [W-1:0]  wd1, wd0, mem_wdata;
  logic rd1, rd0, wr1, wr0, bz1, bz0, dn1, dn0, ov1, ov0;
  logic mem_rd, mem_wr, busy, done, overflow;

  logic [W-1:0] ram [0:255];
  logic [AW+W-1:0] exp_q [$];
  int total = 0;
  int bad = 0;

  always #5 Clk = ~Clk;

  matmul_seq #(.WIDTH(W), .AWIDTH(AW), .ACC_W(24), .SAT(1)) dut (
    .Clk(Clk), .Rst(Rst), .start(start & ~sel),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .mem_rdata(mem_rdata), .mem_addr(a1), .mem_rd(rd1),
    .mem_wr(wr1), .mem_wdata(wd1), .busy(bz1), .done(dn1),
    .overflow(ov1));

  matmul_seq #(.WIDTH(W), .AWIDTH(AW), .ACC_W(24), .SAT(0)) dut0 (
    .Clk(Clk), .Rst(Rst), .start(start & sel),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .mem_rdata(mem_rdata), .mem_addr(a0), .mem_rd(rd0),
    .mem_wr(wr0), .mem_wdata(wd0), .busy(bz0), .done(dn0),
    .overflow(ov0));

  assign mem_addr  = sel ? a0  : a1;
  assign mem_rd    = sel ? rd0 : rd1;
  assign mem_wr    = sel ? wr0 : wr1;
  assign mem_wdata = sel ? wd0 : wd1;
  assign busy      = sel ? bz0 : bz1;
  assign done      = sel ? dn0 : dn1;
  assign overflow  = sel ? ov0 : ov1;

  always @(posedge Clk)
    if (mem_rd) mem_rdata <= ram[mem_addr];

  // Monitor: every write must match the head of the expected queue.
  initial forever begin
    @(negedge Clk);
    if (mem_rd || mem_wr) begin
      total++;
      if (mem_rd && mem_wr) begin
        bad++;
        $display("FAIL strobe_excl rd=%b wr=%b want not both", mem_rd, mem_wr);
      end
    end
    if (mem_wr) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
      end else begin
        logic [AW+W-1:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          bad++;
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                   mem_addr, mem_wdata, e[AW+W-1:W], e[W-1:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic chk_zero_outs(input string nm);
    chk({nm, "_addr"}, 32'(mem_addr), 0);
    chk({nm, "_rd"}, 32'(mem_rd), 0);
    chk({nm, "_wr"}, 32'(mem_wr), 0);
    chk({nm, "_wdata"}, 32'(mem_wdata), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_ovf"}, 32'(overflow), 0);
  endtask

  // inj: 0 plain, 1 = start pulse with new operands at cycle 5,
  //      2 = reset at cycle 3 (MAC of first element)
  task automatic go(input string nm, input int m, input int k, input int n,
                    input int ba, input int bb, input int bc,
                    input int exp_cyc, input int inj, input int exp_ovf);
    int cyc;
    bit saw_busy, saw_mem, fin;
    @(posedge Clk); #1;
    dim_m = AW'(m); dim_k = AW'(k); dim_n = AW'(n);
    base_a = AW'(ba); base_b = AW'(bb); base_c = AW'(bc);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    cyc = 1; saw_busy = 0; saw_mem = 0; fin = 0;
    while (cyc <= 2000 && !fin) begin
      if (busy) saw_busy = 1;
      if (mem_rd || mem_wr) saw_mem = 1;
      if (inj == 1 && cyc == 5) begin
        start = 1'b1;
        dim_m = 1; dim_k = 1; dim_n = 1;
        base_a = 8'h08; base_b = 8'h09; base_c = 8'h30;
      end
      if (inj == 1 && cyc == 6) start = 1'b0;
      if (inj == 2 && cyc == 3) begin
        Rst = 1'b1;
        @(posedge Clk); #1;
        chk_zero_outs({nm, "_rst"});
        Rst = 1'b0;
        return;
      end
      if (done) begin
        fin = 1;
      end else begin
        @(posedge Clk); #1;
        cyc++;
      end
    end
    if (!fin) begin
      bad++; total++;
      $display("FAIL %s_timeout got=none want=%0d", nm, exp_cyc);
      return;
    end
    chk({nm, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
    chk({nm, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    if (exp_cyc == 1) begin
      chk({nm, "_busy_seen"}, 32'(saw_busy), 0);
      chk({nm, "_mem_seen"}, 32'(saw_mem), 0);
    end
    @(posedge Clk); #1;
    chk({nm, "_done_pulse"}, 32'(done), 0);
    chk({nm, "_busy_after"}, 32'(busy), 0);
    chk({nm, "_ovf_hold"}, 32'(overflow), 32'(exp_ovf));
    chk({nm, "_queue_empty"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ram[a] = '0;
    ram[8'h08] = 3; ram[8'h09] = 5;
    ram[8'h00] = 1; ram[8'h01] = 2; ram[8'h02] = 3; ram[8'h03] = 4;
    ram[8'h10] = 5; ram[8'h11] = 6; ram[8'h12] = 7; ram[8'h13] = 8;
    ram[8'h40] = 8'hFF; ram[8'h41] = 8'hFF;
    ram[8'h50] = 8'hFF; ram[8'h51] = 8'hFF;

    repeat (2) @(posedge Clk);
    #1;
    chk_zero_outs("reset");
    Rst = 1'b0;

    push(8'h20, 8'd15);
    go("one", 1, 1, 1, 8'h08, 8'h09, 8'h20, 5, 0, 0);

    push(8'h20, 8'd19); push(8'h21, 8'd22);
    push(8'h22, 8'd43); push(8'h23, 8'd50);
    go("two", 2, 2, 2, 8'h00, 8'h10, 8'h20, 29, 0, 0);

    push(8'h60, 8'hFF);
    go("sat1", 1, 2, 1, 8'h40, 8'h50, 8'h60, 8, 0, 1);

    sel = 1'b1;
    push(8'h60, 8'h02);
    go("sat0", 1, 2, 1, 8'h40, 8'h50, 8'h60, 8, 0, 1);
    sel = 1'b0;

    // overflow from the SAT=1 run must clear on the next accepted start
    go("zero_k", 2, 0, 2, 8'h00, 8'h10, 8'h20, 1, 0, 0);

    go("abort", 2, 2, 2, 8'h00, 8'h10, 8'h20, 0, 2, 0);

    push(8'h20, 8'd19); push(8'h21, 8'd22);
    push(8'h22, 8'd43); push(8'h23, 8'd50);
    go("rerun", 2, 2, 2, 8'h00, 8'h10, 8'h20, 29, 0, 0);

    push(8'h20, 8'd19); push(8'h21, 8'd22);
    push(8'h22, 8'd43); push(8'h23, 8'd50);
    go("busy_start", 2, 2, 2, 8'h00, 8'h10, 8'h20, 29, 1, 0);

    repeat (3) @(posedge Clk);
    #1;
    chk("final_queue", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matmul_seq.md
Name: matmul_seq

Overview:
- Parametrised matrix-multiply sequencer; successor to the fixed 8-bit matrix-multiply processor core.
- Computes C = A x B directly from data RAM using hardwired loop counters, a MAC unit and an FSM. No instruction ROM or microcode.
- Sits beside the data RAM and shares its single-port synchronous interface.
- Adds what the 8-bit core lacks: parametrised data, address and accumulator widths, runtime dimensions and base addresses, selectable saturation, an overflow flag, and a start/busy/done handshake.

Parameters:
WIDTH, 8, element data width (bits)
AWIDTH, 8, RAM address width; also width of the dimension inputs
ACC_W, 24, accumulator width (must be >= 2*WIDTH)
SAT, 1, 1 = saturate result on write; 0 = truncate to low WIDTH bits

Ports:
Clk  input  1  clock; all logic on the rising edge
Rst  input  1  synchronous, active-high reset
start  input  1  begin operation; sampled only in IDLE
dim_m  input  AWIDTH  rows of A / rows of C
dim_k  input  AWIDTH  cols of A / rows of B
dim_n  input  AWIDTH  cols of B / cols of C
base_a  input  AWIDTH  base address of A
base_b  input  AWIDTH  base address of B
base_c  input  AWIDTH  base address of C
mem_rdata  input  WIDTH  RAM read data; valid the cycle after mem_rd
mem_addr  output  AWIDTH  RAM address
mem_rd  output  1  RAM read strobe
mem_wr  output  1  RAM write strobe
mem_wdata  output  WIDTH  RAM write data
busy  output  1  high from the cycle after start is accepted until DONE
done  output  1  one-cycle completion pulse
overflow  output  1  sticky: some C element did not fit in WIDTH bits

Behaviour:
- Reset: one clock, synchronous, active-high. Rst=1 forces state IDLE and zeroes all outputs, counters i/j/k, acc, a_reg and the latched operands. Rst mid-operation aborts at once; no further RAM access occurs.
- Layout: all matrices row-major, unsigned.
  - A[i][k] at base_a + i*K + k
  - B[k][j] at base_b + k*N + j
  - C[i][j] at base_c + i*N + j
  - Address arithmetic wraps modulo 2^AWIDTH.
- Operand latching: dims and bases are latched when start is accepted. Later input changes have no effect until the next start.
- Strobes: mem_rd and mem_wr are never high together. mem_addr and mem_wdata are 0 whenever their strobe is low.
- FSM states: IDLE, RDA, RDB, MAC, WR, DONE.
  - IDLE: busy=0. On start=1, latch operands, clear acc, i, j, k and overflow.
    - Any dimension = 0: go to DONE (no RAM access).
    - Otherwise: go to RDA.
    - start while not in IDLE is ignored.
  - RDA: mem_rd=1, mem_addr=A addr. Go to RDB.
  - RDB: mem_rd=1, mem_addr=B addr; a_reg <= mem_rdata. Go to MAC.
  - MAC: acc <= acc + a_reg*mem_rdata, modulo 2^ACC_W.
    - k==K-1: go to WR.
    - Otherwise: k++, go to RDA.
  - WR: mem_wr=1, mem_addr=C addr.
    - Result fits (acc <= 2^WIDTH-1): mem_wdata = acc.
    - Result too large: SAT=1 writes all-ones, SAT=0 writes acc[WIDTH-1:0]; overflow is set in either case.
    - Then clear acc and k.
    - i==M-1 and j==N-1: go to DONE.
    - j==N-1 only: j=0, i++, go to RDA.
    - Otherwise: j++, go to RDA.
  - DONE: done=1 for one cycle, busy=0. Go to IDLE. overflow holds until the next accepted start or Rst.
- Timing:
  - Each C element takes 3K+1 cycles.
  - With start sampled at edge 0, done is high in cycle M*N*(3K+1)+1.
  - Zero-dimension case: done is high in cycle 1.
- Wrap-around: accumulator wrap at ACC_W is silent. It is not detected as overflow beyond the WR check above.

Test Plan:
- M=K=N=1, A=3, B=5, base_c=0x20 -> exactly one write, 0x20<-15; done in cycle 5; overflow=0.
- 2x2 x 2x2, A=[1,2;3,4], B=[5,6;7,8] -> C=[19,22;43,50] written in order c00,c01,c10,c11; done in cycle 29.
- SAT=1, K=2, all A=B=0xFF -> acc=0x1FC02; write 0xFF; overflow=1. Repeat with SAT=0 -> write 0x02; overflow=1.
- dim_k=0 with start -> mem_rd and mem_wr stay 0; done in cycle 1; busy stays 0.
- Rst asserted mid-run in MAC state -> next cycle: IDLE, all outputs 0. A new start then runs the multiply fully and correctly.
- start pulsed while busy, with dims changed at the same time -> ignored; the result uses the originally latched dims and bases.
